eff_clip_pipe: RTL and testbench

Parametrised, pipelined clipping effect for the audio sample path. It sits between the receive stage and the transmit stage, like the first-generation byte clipper. It adds:
- signed samples of any width
- run-time selectable hard, asymmetric and fold-back modes
- validated threshold loading
- per-sample clip flag, saturating clip counter and peak-magnitude hold

---
 rtl/eff_pkg.sv | 13 +
 rtl/eff_sat_counter.sv | 33 +++
 rtl/eff_clip_pipe.sv | 215 +++++++++++++++++++++
 tb/tb_eff_clip_pipe.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/eff_pkg.sv
// Shared types and constants for the clipping effect pipeline.
package eff_pkg;

    localparam int MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        BYPASS    = 2'd0,
        HARD_SYM  = 2'd1,
        HARD_ASYM = 2'd2,
        FOLD      = 2'd3
    } clip_mode_e;

endpackage

// File: rtl/eff_sat_counter.sv
// Up-counter that sticks at all-ones; clear has priority over increment.
module eff_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         srst,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/eff_clip_pipe.sv
// Two-stage signed clipper with hard, asymmetric and fold-back modes,
// validated threshold loading, clip counting and peak-magnitude hold.
module eff_clip_pipe
    import eff_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16,
    parameter int DEF_HI = 100
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_sample,
    input  logic              i_cfg_load,
    input  logic [MODE_W-1:0] i_mode,
    input  logic [DATA_W-1:0] i_thr_hi,
    input  logic [DATA_W-1:0] i_thr_lo,
    input  logic              i_cnt_clr,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_sample,
    output logic              o_clip,
    output logic [CNT_W-1:0]  o_clip_cnt,
    output logic [DATA_W-2:0] o_peak,
    output logic              o_cfg_err
);

    localparam logic [DATA_W-1:0] DEF_HI_V = DATA_W'(DEF_HI);
    localparam logic [DATA_W-1:0] DEF_LO_V = DATA_W'(-DEF_HI);

    logic signed [DATA_W-1:0] x_s, thr_hi_s, thr_lo_s;
    assign x_s      = $signed(i_sample);
    assign thr_hi_s = $signed(i_thr_hi);
    assign thr_lo_s = $signed(i_thr_lo);

    // ---------------- active configuration ----------------
    clip_mode_e               mode_q, mode_d, ld_mode;
    logic signed [DATA_W-1:0] hi_q, hi_d, lo_q, lo_d;
    logic                     cfg_err_q, cfg_err_d;
    logic                     ld_ok;

    always_comb begin
        ld_mode = clip_mode_e'(i_mode);
        case (ld_mode)
            HARD_SYM:        ld_ok = ~thr_hi_s[DATA_W-1];
            HARD_ASYM, FOLD: ld_ok = (thr_lo_s <= thr_hi_s);
            default:         ld_ok = 1'b1;
        endcase
    end

    always_comb begin
        mode_d    = mode_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        cfg_err_d = 1'b0;
        if (i_cfg_load) begin
            if (ld_ok) begin
                mode_d = ld_mode;
                hi_d   = thr_hi_s;
                lo_d   = (ld_mode == HARD_SYM) ? -thr_hi_s : thr_lo_s;
            end else begin
                cfg_err_d = 1'b1;
            end
        end
    end

    // ---------------- stage 1: capture sample, flags and config ----------------
    logic                     s1_valid_q, s1_valid_d;
    logic signed [DATA_W-1:0] s1_x_q, s1_x_d, s1_hi_q, s1_hi_d, s1_lo_q, s1_lo_d;
    logic                     s1_gt_q, s1_gt_d, s1_lt_q, s1_lt_d;
    clip_mode_e               s1_mode_q, s1_mode_d;

    always_comb begin
        s1_valid_d = i_valid;
        s1_x_d     = s1_x_q;
        s1_hi_d    = s1_hi_q;
        s1_lo_d    = s1_lo_q;
        s1_gt_d    = s1_gt_q;
        s1_lt_d    = s1_lt_q;
        s1_mode_d  = s1_mode_q;
        if (i_valid) begin
            s1_x_d    = x_s;
            s1_hi_d   = hi_q;
            s1_lo_d   = lo_q;
            s1_gt_d   = (x_s > hi_q);
            s1_lt_d   = (x_s < lo_q);
            s1_mode_d = mode_q;
        end
    end

    // ---------------- stage 2: produce output sample ----------------
    logic signed [DATA_W+1:0] x_e, hi_e, lo_e, fold_e;
    logic signed [DATA_W-1:0] y_comb;
    logic                     clip_comb;
    logic                     o_valid_q, o_valid_d, o_clip_q, o_clip_d;
    logic [DATA_W-1:0]        o_sample_q, o_sample_d;

    always_comb begin
        x_e  = {{2{s1_x_q[DATA_W-1]}},  s1_x_q};
        hi_e = {{2{s1_hi_q[DATA_W-1]}}, s1_hi_q};
        lo_e = {{2{s1_lo_q[DATA_W-1]}}, s1_lo_q};
        // Reflection can overshoot the opposite threshold, hence the clamp.
        fold_e = x_e;
        if (s1_gt_q) begin
            fold_e = (hi_e <<< 1) - x_e;
        end else if (s1_lt_q) begin
            fold_e = (lo_e <<< 1) - x_e;
        end
        if (fold_e > hi_e) begin
            fold_e = hi_e;
        end else if (fold_e < lo_e) begin
            fold_e = lo_e;
        end

        y_comb    = s1_x_q;
        clip_comb = 1'b0;
        case (s1_mode_q)
            HARD_SYM, HARD_ASYM: begin
                if (s1_gt_q) begin
                    y_comb = s1_hi_q;
                end else if (s1_lt_q) begin
                    y_comb = s1_lo_q;
                end
                clip_comb = s1_gt_q | s1_lt_q;
            end
            FOLD: begin
                y_comb    = fold_e[DATA_W-1:0];
                clip_comb = s1_gt_q | s1_lt_q;
            end
            default: begin
                y_comb    = s1_x_q;
                clip_comb = 1'b0;
            end
        endcase
    end

    always_comb begin
        o_valid_d  = s1_valid_q;
        o_sample_d = o_sample_q;
        o_clip_d   = o_clip_q;
        if (s1_valid_q) begin
            o_sample_d = y_comb;
            o_clip_d   = clip_comb;
        end
    end

    // ---------------- peak magnitude hold ----------------
    logic [DATA_W-2:0] abs_x, peak_q, peak_d;

    always_comb begin
        if (i_sample == {1'b1, {(DATA_W-1){1'b0}}}) begin
            abs_x = '1;
        end else if (i_sample[DATA_W-1]) begin
            abs_x = ~i_sample[DATA_W-2:0] + (DATA_W-1)'(1);
        end else begin
            abs_x = i_sample[DATA_W-2:0];
        end
        peak_d = peak_q;
        if (i_cnt_clr) begin
            peak_d = '0;
        end else if (i_valid && (abs_x > peak_q)) begin
            peak_d = abs_x;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            mode_q     <= HARD_SYM;
            hi_q       <= DEF_HI_V;
            lo_q       <= DEF_LO_V;
            cfg_err_q  <= 1'b0;
            s1_valid_q <= 1'b0;
            s1_x_q     <= '0;
            s1_hi_q    <= '0;
            s1_lo_q    <= '0;
            s1_gt_q    <= 1'b0;
            s1_lt_q    <= 1'b0;
            s1_mode_q  <= BYPASS;
            o_valid_q  <= 1'b0;
            o_sample_q <= '0;
            o_clip_q   <= 1'b0;
            peak_q     <= '0;
        end else begin
            mode_q     <= mode_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            cfg_err_q  <= cfg_err_d;
            s1_valid_q <= s1_valid_d;
            s1_x_q     <= s1_x_d;
            s1_hi_q    <= s1_hi_d;
            s1_lo_q    <= s1_lo_d;
            s1_gt_q    <= s1_gt_d;
            s1_lt_q    <= s1_lt_d;
            s1_mode_q  <= s1_mode_d;
            o_valid_q  <= o_valid_d;
            o_sample_q <= o_sample_d;
            o_clip_q   <= o_clip_d;
            peak_q     <= peak_d;
        end
    end

    eff_sat_counter #(.W(CNT_W)) u_clip_cnt (
        .clk  (i_clk),
        .srst (i_rst),
        .en   (o_valid_q & o_clip_q),
        .clr  (i_cnt_clr),
        .cnt  (o_clip_cnt)
    );

    assign o_valid   = o_valid_q;
    assign o_sample  = o_sample_q;
    assign o_clip    = o_clip_q;
    assign o_peak    = peak_q;
    assign o_cfg_err = cfg_err_q;

endmodule

// File: tb/tb_eff_clip_pipe.sv
// Scenario bench for eff_clip_pipe against a cycle-level arithmetic reference model.
module tb_eff_clip_pipe;

    localparam int DATA_W  = 8;
    localparam int CNT_W   = 2;
    localparam int DEF_HI  = 100;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
    localparam int PK_MAX  = (1 << (DATA_W - 1)) - 1;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              i_valid = 1'b0;
    logic [DATA_W-1:0] i_sample = '0;
    logic              i_cfg_load = 1'b0;
    logic [1:0]        i_mode = '0;
    logic [DATA_W-1:0] i_thr_hi = '0;
    logic [DATA_W-1:0] i_thr_lo = '0;
    logic              i_cnt_clr = 1'b0;
    logic              o_valid, o_clip, o_cfg_err;
    logic [DATA_W-1:0] o_sample;
    logic [CNT_W-1:0]  o_clip_cnt;
    logic [DATA_W-2:0] o_peak;

    always #5 clk = ~clk;

    eff_clip_pipe #(.DATA_W(DATA_W), .CNT_W(CNT_W), .DEF_HI(DEF_HI)) dut (
        .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .i_sample(i_sample),
        .i_cfg_load(i_cfg_load), .i_mode(i_mode), .i_thr_hi(i_thr_hi),
        .i_thr_lo(i_thr_lo), .i_cnt_clr(i_cnt_clr), .o_valid(o_valid),
        .o_sample(o_sample), .o_clip(o_clip), .o_clip_cnt(o_clip_cnt),
        .o_peak(o_peak), .o_cfg_err(o_cfg_err)
    );

    typedef struct {
        bit v;
        int y;
        bit clip;
    } exp_t;

    int   tests_run = 0;
    int   tests_failed = 0;
    int   m_mode, m_hi, m_lo, m_cnt, m_peak, hold_y;
    bit   hold_clip;
    exp_t stg_a, stg_b;

    function automatic void ref_clip(input int x, input int mode, input int hi, input int lo,
                                     output int y, output bit clip);
        int t;
        clip = (mode != 0) && (x > hi || x < lo);
        if (mode == 0) begin
            y = x;
        end else if (mode == 3) begin
            t = (x > hi) ? 2 * hi - x : (x < lo) ? 2 * lo - x : x;
            y = (t > hi) ? hi : (t < lo) ? lo : t;
        end else begin
            y = (x > hi) ? hi : (x < lo) ? lo : x;
        end
    endfunction

    task automatic model_reset();
        m_mode = 1; m_hi = DEF_HI; m_lo = -DEF_HI;
        m_cnt = 0; m_peak = 0; hold_y = 0; hold_clip = 0;
        stg_a = '{0, 0, 0};
        stg_b = '{0, 0, 0};
    endtask

    // One clock of stimulus; checks every observable output after the edge.
    task automatic cycle(input bit v, input int x, input bit ld, input int mode,
                         input int hi, input int lo, input bit clr, input string tag);
        exp_t nw;
        bit   ok;
        bit   exp_err;
        int   ax;
        i_valid = v; i_sample = DATA_W'(x); i_cfg_load = ld; i_mode = 2'(mode);
        i_thr_hi = DATA_W'(hi); i_thr_lo = DATA_W'(lo); i_cnt_clr = clr;
        nw.v = v;
        ref_clip(x, m_mode, m_hi, m_lo, nw.y, nw.clip);
        exp_err = 1'b0;
        if (ld) begin
            ok = (mode == 1) ? (hi >= 0) : (mode >= 2) ? (lo <= hi) : 1'b1;
            if (ok) begin
                m_mode = mode; m_hi = hi; m_lo = (mode == 1) ? -hi : lo;
            end else begin
                exp_err = 1'b1;
            end
        end
        if (clr) begin
            m_peak = 0;
        end else if (v) begin
            ax = (x < 0) ? -x : x;
            if (ax > PK_MAX) ax = PK_MAX;
            if (ax > m_peak) m_peak = ax;
        end
        if (clr) m_cnt = 0;
        else if (stg_b.v && stg_b.clip && m_cnt < CNT_MAX) m_cnt++;
        @(posedge clk); #1;
        if (stg_a.v) begin
            hold_y = stg_a.y; hold_clip = stg_a.clip;
        end
        tests_run += 6;
        if (o_valid !== stg_a.v) begin
            tests_failed++; $display("FAIL %s valid got %0b want %0b", tag, o_valid, stg_a.v);
        end
        if (o_sample !== DATA_W'(hold_y)) begin
            tests_failed++; $display("FAIL %s sample got %0d want %0d", tag, $signed(o_sample), hold_y);
        end
        if (o_clip !== hold_clip) begin
            tests_failed++; $display("FAIL %s clip got %0b want %0b", tag, o_clip, hold_clip);
        end
        if (o_cfg_err !== exp_err) begin
            tests_failed++; $display("FAIL %s cfg_err got %0b want %0b", tag, o_cfg_err, exp_err);
        end
        if (o_clip_cnt !== CNT_W'(m_cnt)) begin
            tests_failed++; $display("FAIL %s clip_cnt got %0d want %0d", tag, o_clip_cnt, m_cnt);
        end
        if (o_peak !== (DATA_W-1)'(m_peak)) begin
            tests_failed++; $display("FAIL %s peak got %0d want %0d", tag, o_peak, m_peak);
        end
        $display("[TB] %s v=%0b x=%0d ld=%0b clr=%0b -> v=%0b y=%0d clip=%0b err=%0b cnt=%0d pk=%0d",
                 tag, v, x, ld, clr, o_valid, $signed(o_sample), o_clip, o_cfg_err, o_clip_cnt, o_peak);
        stg_b = stg_a;
        stg_a = nw;
    endtask

    task automatic send(input int x, input string tag);
        cycle(1'b1, x, 1'b0, 0, 0, 0, 1'b0, tag);
    endtask

    task automatic idle(input int n, input string tag);
        for (int k = 0; k < n; k++) cycle(1'b0, 0, 1'b0, 0, 0, 0, 1'b0, tag);
    endtask

    task automatic load(input int mode, input int hi, input int lo, input string tag);
        cycle(1'b0, 0, 1'b1, mode, hi, lo, 1'b0, tag);
    endtask

    task automatic do_reset();
        rst = 1'b1; i_valid = 1'b0; i_cfg_load = 1'b0; i_cnt_clr = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        tests_run += 6;
        if (o_valid !== 1'b0)    begin tests_failed++; $display("FAIL rst_valid got %0b want 0", o_valid); end
        if (o_sample !== '0)     begin tests_failed++; $display("FAIL rst_sample got %0d want 0", o_sample); end
        if (o_clip !== 1'b0)     begin tests_failed++; $display("FAIL rst_clip got %0b want 0", o_clip); end
        if (o_clip_cnt !== '0)   begin tests_failed++; $display("FAIL rst_cnt got %0d want 0", o_clip_cnt); end
        if (o_peak !== '0)       begin tests_failed++; $display("FAIL rst_peak got %0d want 0", o_peak); end
        if (o_cfg_err !== 1'b0)  begin tests_failed++; $display("FAIL rst_err got %0b want 0", o_cfg_err); end
        $display("[TB] reset checked");
    endtask

    task automatic test_default();
        send(120, "def"); send(-120, "def"); send(50, "def");
        idle(3, "def");
        tests_run++;
        if (o_clip_cnt !== CNT_W'(2)) begin
            tests_failed++; $display("FAIL def_cnt got %0d want 2", o_clip_cnt);
        end
    endtask

    task automatic test_bad_load();
        load(2, 5, 10, "badld");
        send(120, "badld");
        idle(2, "badld");
        tests_run++;
        if (o_sample !== DATA_W'(100)) begin
            tests_failed++; $display("FAIL badld_old_cfg got %0d want 100", $signed(o_sample));
        end
    endtask

    task automatic test_asym();
        load(2, 60, -20, "asym");
        send(70, "asym"); send(-30, "asym"); send(0, "asym");
        idle(2, "asym");
    endtask

    task automatic test_fold();
        load(3, 50, -50, "fold");
        send(80, "fold"); send(-70, "fold"); send(127, "fold");
        idle(2, "fold");
    endtask

    task automatic test_sat();
        load(1, 100, 0, "sat");
        cycle(1'b0, 0, 1'b0, 0, 0, 0, 1'b1, "sat_clr");
        for (int k = 0; k < 5; k++) send(120, "sat");
        idle(3, "sat");
        send(120, "satclr"); send(120, "satclr");
        cycle(1'b0, 0, 1'b0, 0, 0, 0, 1'b1, "satclr");
        tests_run++;
        if (o_clip_cnt !== '0) begin
            tests_failed++; $display("FAIL satclr_cnt got %0d want 0", o_clip_cnt);
        end
        idle(2, "satclr");
    endtask

    task automatic test_peak();
        cycle(1'b0, 0, 1'b0, 0, 0, 0, 1'b1, "peak_clr");
        send(-128, "peak"); send(100, "peak");
        idle(1, "peak");
        tests_run++;
        if (o_peak !== (DATA_W-1)'(127)) begin
            tests_failed++; $display("FAIL peak_hold got %0d want 127", o_peak);
        end
    endtask

    task automatic test_simul_load();
        load(1, 100, 0, "simul");
        cycle(1'b1, 80, 1'b1, 1, 30, 0, 1'b0, "simul");
        send(80, "simul");
        idle(2, "simul");
    endtask

    task automatic test_back_to_back();
        int mode, hi, lo, t;
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(15) == 0) begin
                mode = int'($urandom_range(3));
                hi = int'($urandom_range(255)) - 128;
                lo = int'($urandom_range(255)) - 128;
                if ($urandom_range(3) != 0 && lo > hi) begin t = lo; lo = hi; hi = t; end
                if (mode == 1 && $urandom_range(3) != 0 && hi < 0) hi = -hi - 1;
                cycle($urandom_range(1) == 1, int'($urandom_range(255)) - 128, 1'b1, mode, hi, lo,
                      $urandom_range(31) == 0, "rand");
            end else begin
                cycle($urandom_range(3) != 0, int'($urandom_range(255)) - 128, 1'b0, 0, 0, 0,
                      $urandom_range(31) == 0, "rand");
            end
        end
        idle(2, "rand");
    endtask

    task automatic test_flush();
        load(1, 100, 0, "flush");
        send(120, "flush"); send(-50, "flush");
        do_reset();
        idle(3, "flush");
    endtask

    initial begin
        model_reset();
        test_reset();
        test_default();
        test_bad_load();
        test_asym();
        test_fold();
        test_sat();
        test_peak();
        test_simul_load();
        test_back_to_back();
        test_flush();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
